// File: rtl/unibus_pkg.sv
// Shared Unibus definitions: arbiter FSM encoding, grant selector codes,
// register identification and bus timing constants used by the DMA engines.
package unibus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2,
    ST_SACKED = 2'd3
  } arb_state_t;

  // Selector codes double as priority rank: lower code wins.
  localparam logic [2:0] SEL_NPR = 3'd0;
  localparam logic [2:0] SEL_BR7 = 3'd1;
  localparam logic [2:0] SEL_BR6 = 3'd2;
  localparam logic [2:0] SEL_BR5 = 3'd3;
  localparam logic [2:0] SEL_BR4 = 3'd4;

  localparam logic [31:0] REG_ID  = 32'h4241_2001;
  localparam logic [31:0] REG_BAD = 32'hDEAD_BEEF;

  localparam int BUS_150NS_CLKS = 15;
  localparam int BUS_10US_CLKS  = 1023;

  // Grant pattern {npg, bg7, bg6, bg5, bg4} for a selector code.
  function automatic logic [4:0] sel_onehot(input logic [2:0] sel);
    logic [4:0] g;
    g = 5'b00000;
    case (sel)
      SEL_NPR: g = 5'b10000;
      SEL_BR7: g = 5'b01000;
      SEL_BR6: g = 5'b00100;
      SEL_BR5: g = 5'b00010;
      SEL_BR4: g = 5'b00001;
      default: g = 5'b00000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/unibus_sync2.sv
// Two-flop synchroniser for asynchronous Unibus control lines.
module unibus_sync2 #(
  parameter int W = 1
) (
  input  logic         CLOCK,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge CLOCK) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
  end

  assign q = sync_p1;

endmodule

// File: rtl/unibus_arbiter.sv
// Unibus NPR/BR arbiter: settles requests, issues one daisy-chain grant,
// completes the SACK handshake and exposes status/statistics to the ARM.
module unibus_arbiter
  import unibus_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SACK_TIMEOUT  = BUS_10US_CLKS,
  parameter int CNT_W         = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  input  logic        npr_in_h,
  input  logic [3:0]  br_in_h,
  input  logic        sack_in_h,
  input  logic [2:0]  cpu_pri,
  input  logic        halted,
  output logic        npg_out_h,
  output logic [3:0]  bg_out_h
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(SACK_TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             npr_s, sack_s;
  logic [3:0]       br_s;
  arb_state_t       state, state_n;
  logic [SET_W-1:0] scnt, scnt_n;
  logic [TO_W-1:0]  tcnt, tcnt_n;
  logic [2:0]       sel, sel_n, best_sel;
  logic [4:0]       req, elig, grant_n;
  logic             grant_ev, nosack_ev;
  logic             enable;
  logic [CNT_W-1:0] grant_count, nosack_count;
  logic [1:0]       state_bits;
  logic             unused_wdata;

  unibus_sync2 #(.W(1)) u_sync_npr  (.CLOCK(CLOCK), .d(npr_in_h),  .q(npr_s));
  unibus_sync2 #(.W(4)) u_sync_br   (.CLOCK(CLOCK), .d(br_in_h),   .q(br_s));
  unibus_sync2 #(.W(1)) u_sync_sack (.CLOCK(CLOCK), .d(sack_in_h), .q(sack_s));

  // Requests indexed by selector code; BRn is eligible only above cpu_pri.
  always_comb begin
    req      = {br_s[0], br_s[1], br_s[2], br_s[3], npr_s};
    elig     = 5'b00000;
    elig[0]  = enable & req[0];
    for (int i = 1; i < 5; i++) begin
      elig[i] = enable & ~halted & req[i] & (cpu_pri < 3'(8 - i));
    end
    best_sel = SEL_NPR;
    for (int i = 4; i >= 0; i--) begin
      if (elig[i]) best_sel = 3'(i);
    end
  end

  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    tcnt_n    = tcnt;
    sel_n     = sel;
    grant_ev  = 1'b0;
    nosack_ev = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!sack_s && (|elig)) begin
          state_n = ST_SETTLE;
          scnt_n  = '0;
        end
      end
      ST_SETTLE: begin
        if (!(|elig)) begin
          state_n = ST_IDLE;
        end else if (scnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_n  = ST_GRANT;
          sel_n    = best_sel;
          tcnt_n   = '0;
          grant_ev = 1'b1;
        end else begin
          scnt_n = scnt + SET_W'(1);
        end
      end
      ST_GRANT: begin
        if (sack_s) begin
          state_n = ST_SACKED;
        end else if (!req[sel]) begin
          state_n = ST_IDLE;
        end else if (tcnt == TO_W'(SACK_TIMEOUT)) begin
          state_n   = ST_IDLE;
          nosack_ev = 1'b1;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
      end
      ST_SACKED: begin
        if (!sack_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    grant_n = (state_n == ST_GRANT) ? sel_onehot(sel_n) : 5'b00000;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || init_in_h) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      tcnt      <= '0;
      sel       <= SEL_NPR;
      npg_out_h <= 1'b0;
      bg_out_h  <= 4'b0000;
    end else begin
      state                 <= state_n;
      scnt                  <= scnt_n;
      tcnt                  <= tcnt_n;
      sel                   <= sel_n;
      {npg_out_h, bg_out_h} <= grant_n;
    end
  end

  // INIT keeps enable and statistics; an ARM clear beats a same-cycle event.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      grant_count  <= '0;
      nosack_count <= '0;
    end else if (armwrite && armwaddr == 3'd2) begin
      grant_count  <= '0;
      nosack_count <= '0;
    end else begin
      if (grant_ev && !init_in_h)  grant_count  <= sat_inc(grant_count);
      if (nosack_ev && !init_in_h) nosack_count <= sat_inc(nosack_count);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable <= 1'b0;
    end else if (armwrite && armwaddr == 3'd1) begin
      enable <= armwdata[31];
    end
  end

  assign state_bits   = state;
  assign unused_wdata = ^armwdata[30:0];

  always_comb begin
    armrdata = REG_BAD;
    case (armraddr)
      3'd0: armrdata = REG_ID;
      3'd1: armrdata = {enable, 1'b0, state_bits, npg_out_h, bg_out_h, 23'b0};
      3'd2: armrdata = {16'(nosack_count), 16'(grant_count)};
      default: armrdata = REG_BAD;
    endcase
  end

endmodule

// File: tb/tb_unibus_arbiter.sv
// Bench for unibus_arbiter: directed bus scenarios plus randomized request
// patterns checked against a priority-rule reference model.
module tb_unibus_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armraddr;
  logic [2:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        init_in_h;
  logic        npr_in_h;
  logic [3:0]  br_in_h;
  logic        sack_in_h;
  logic [2:0]  cpu_pri;
  logic        halted;
  logic        npg_out_h;
  logic [3:0]  bg_out_h;

  int checks = 0;
  int errors = 0;
  int exp_gcnt = 0;
  int exp_ncnt = 0;

  unibus_arbiter dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .init_in_h(init_in_h), .npr_in_h(npr_in_h), .br_in_h(br_in_h),
    .sack_in_h(sack_in_h), .cpu_pri(cpu_pri), .halted(halted),
    .npg_out_h(npg_out_h), .bg_out_h(bg_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic get_state(output logic [31:0] s);
    logic [31:0] r;
    read_reg(3'd1, r);
    s = {29'b0, r[30:28]};
  endtask

  task automatic arm_write(input logic [2:0] a, input logic [31:0] d);
    armwaddr = a;
    armwdata = d;
    armwrite = 1'b1;
    tick(1);
    armwrite = 1'b0;
  endtask

  function automatic logic [4:0] grants();
    return {npg_out_h, bg_out_h};
  endfunction

  task automatic wait_grant(input int limit, output logic [4:0] g);
    int n = 0;
    g = grants();
    while (g == 5'd0 && n < limit) begin
      tick(1);
      n++;
      g = grants();
    end
  endtask

  // Device answers SACK and withdraws its request, then takes the bus.
  task automatic handshake(input logic [3:0] br_keep);
    sack_in_h = 1'b1;
    npr_in_h  = 1'b0;
    br_in_h   = br_keep;
    tick(3);
    sack_in_h = 1'b0;
    tick(5);
  endtask

  // Reference: the winning grant {npg, bg7..bg4} from the priority rules.
  function automatic logic [4:0] model_grant(input bit en, input bit npr,
                                             input logic [3:0] br, input int pri,
                                             input bit hlt);
    if (!en) return 5'd0;
    if (npr) return 5'b10000;
    if (hlt) return 5'd0;
    for (int lvl = 7; lvl >= 4; lvl--) begin
      if (br[lvl - 4] && lvl > pri) return 5'(1) << (lvl - 4);
    end
    return 5'd0;
  endfunction

  initial begin
    logic [31:0] r, s, saved;
    logic [4:0]  g, e;
    int          bad, hc;
    bit          en, rnpr, rhalt;
    logic [3:0]  rbr;
    int          rpri;

    RESET = 1'b1; armwrite = 1'b0; armraddr = 3'd0; armwaddr = 3'd0;
    armwdata = 32'd0; init_in_h = 1'b0; npr_in_h = 1'b0; br_in_h = 4'd0;
    sack_in_h = 1'b0; cpu_pri = 3'd0; halted = 1'b0;
    tick(4);
    RESET = 1'b0;
    tick(1);

    // Reset state and identification registers.
    check("reset_grants", 32'(grants()), 32'd0);
    read_reg(3'd0, r); check("reg_id", r, 32'h4241_2001);
    read_reg(3'd1, r); check("reset_status", r, 32'd0);
    read_reg(3'd2, r); check("reset_counts", r, 32'd0);
    read_reg(3'd5, r); check("bad_addr", r, 32'hDEAD_BEEF);

    arm_write(3'd1, 32'h8000_0000);
    read_reg(3'd1, r); check("enable_set", {31'b0, r[31]}, 32'd1);

    // NPR grant latency and SACK handshake.
    npr_in_h = 1'b1;
    tick(10); check("npr_not_yet", 32'(grants()), 32'd0);
    tick(1);  check("npr_latency", 32'(grants()), 32'h10);
    exp_gcnt++;
    sack_in_h = 1'b1;
    tick(2);  check("npg_held_pre_sack", 32'(grants()), 32'h10);
    tick(1);  check("npg_drop_sack", 32'(grants()), 32'd0);
    get_state(s); check("state_sacked", s, 32'd3);
    sack_in_h = 1'b0; npr_in_h = 1'b0;
    tick(3); get_state(s); check("state_idle_after_sack", s, 32'd0);
    read_reg(3'd2, r); check("gcount_1", r, 32'd1);

    // Priority: NPR beats BR7; BR4 is below cpu_pri 5.
    cpu_pri = 3'd5; br_in_h = 4'b1001; npr_in_h = 1'b1;
    wait_grant(20, g); check("prio_npr_first", 32'(g), 32'h10);
    exp_gcnt++;
    handshake(4'b1001);
    wait_grant(20, g); check("prio_br7_second", 32'(g), 32'h08);
    exp_gcnt++;
    handshake(4'b0001);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1); get_state(s);
      if (grants() != 5'd0 || s != 32'd0) bad++;
    end
    check("br4_never_granted", 32'(bad), 32'd0);
    br_in_h = 4'd0;

    // Requests at or below cpu_pri, or BR while halted, are never granted.
    cpu_pri = 3'd6; br_in_h = 4'b0100;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1); get_state(s);
      if (grants() != 5'd0 || s != 32'd0) bad++;
    end
    check("br6_at_pri6_blocked", 32'(bad), 32'd0);
    cpu_pri = 3'd0; br_in_h = 4'b1000; halted = 1'b1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1); get_state(s);
      if (grants() != 5'd0 || s != 32'd0) bad++;
    end
    check("br7_halted_blocked", 32'(bad), 32'd0);
    br_in_h = 4'd0; halted = 1'b0;
    tick(4);

    // SACK timeout, then regrant of the still-held NPR.
    npr_in_h = 1'b1;
    wait_grant(20, g); check("timeout_grant", 32'(g), 32'h10);
    exp_gcnt++;
    hc = 0;
    while (npg_out_h && hc < 2000) begin
      tick(1); hc++;
    end
    check("timeout_high_cycles", 32'(hc), 32'd1024);
    exp_ncnt++;
    get_state(s); check("timeout_state", s, 32'd0);
    read_reg(3'd2, r); check("timeout_counts", r, {16'(exp_ncnt), 16'(exp_gcnt)});
    wait_grant(20, g); check("npr_regrant", 32'(g), 32'h10);
    exp_gcnt++;
    npr_in_h = 1'b0;
    tick(3); check("npr_withdraw_drop", 32'(grants()), 32'd0);
    get_state(s); check("npr_withdraw_state", s, 32'd0);
    tick(4);

    // BR5 withdrawn before SACK leaves counters untouched.
    cpu_pri = 3'd3; br_in_h = 4'b0010;
    wait_grant(20, g); check("br5_grant", 32'(g), 32'h02);
    exp_gcnt++;
    read_reg(3'd2, saved);
    br_in_h = 4'd0;
    tick(3); check("br5_withdraw_drop", 32'(grants()), 32'd0);
    get_state(s); check("br5_withdraw_state", s, 32'd0);
    read_reg(3'd2, r); check("br5_counts_same", r, saved);
    cpu_pri = 3'd0;
    tick(4);

    // INIT mid-grant clears the bus side but keeps enable and counters.
    npr_in_h = 1'b1;
    wait_grant(20, g); check("init_pre_grant", 32'(g), 32'h10);
    exp_gcnt++;
    init_in_h = 1'b1;
    tick(1);
    init_in_h = 1'b0; npr_in_h = 1'b0;
    check("init_grants", 32'(grants()), 32'd0);
    read_reg(3'd1, r); check("init_status", {28'b0, r[31:28]}, 32'h8);
    read_reg(3'd2, r); check("init_counts", r, {16'(exp_ncnt), 16'(exp_gcnt)});
    tick(6);

    // Clearing enable during GRANT keeps the grant but blocks the next one.
    npr_in_h = 1'b1;
    wait_grant(20, g); check("dis_grant", 32'(g), 32'h10);
    exp_gcnt++;
    arm_write(3'd1, 32'h0);
    check("dis_grant_held", 32'(grants()), 32'h10);
    sack_in_h = 1'b1; tick(3); sack_in_h = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1); if (grants() != 5'd0) bad++;
    end
    check("dis_no_regrant", 32'(bad), 32'd0);
    npr_in_h = 1'b0;
    read_reg(3'd2, r); check("dis_counts", r, {16'(exp_ncnt), 16'(exp_gcnt)});
    arm_write(3'd2, 32'h0);
    exp_gcnt = 0; exp_ncnt = 0;
    read_reg(3'd2, r); check("count_clear", r, 32'd0);
    tick(4);

    // Randomized request patterns against the priority model.
    for (int t = 0; t < 24; t++) begin
      en = ($urandom_range(0, 7) != 0);
      arm_write(3'd1, {en, 31'b0});
      rnpr  = ($urandom_range(0, 3) == 0);
      rbr   = 4'($urandom);
      rpri  = $urandom_range(0, 7);
      rhalt = ($urandom_range(0, 7) == 0);
      cpu_pri = 3'(rpri); halted = rhalt;
      npr_in_h = rnpr; br_in_h = rbr;
      e = model_grant(en, rnpr, rbr, rpri, rhalt);
      if (e != 5'd0) begin
        tick(10); check("rand_early", 32'(grants()), 32'd0);
        tick(1);  check("rand_grant", 32'(grants()), 32'(e));
        exp_gcnt++;
        handshake(4'd0);
      end else begin
        bad = 0;
        for (int i = 0; i < 30; i++) begin
          tick(1); if (grants() != 5'd0) bad++;
        end
        check("rand_none", 32'(bad), 32'd0);
        npr_in_h = 1'b0; br_in_h = 4'd0;
        tick(4);
      end
    end
    read_reg(3'd2, r); check("rand_counts", r, {16'(exp_ncnt), 16'(exp_gcnt)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
